// File: rtl/shift_sequencer.sv
// shift_sequencer
// Multi-cycle shifter for the single-cycle core: performs SLL/SRL/SRA/ROR
// one bit per clock and stalls PC/writeback until the result is ready.
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   start   request a shift (sampled only in IDLE)
//   op      00 SLL, 01 SRL, 10 SRA, 11 ROR
//   src     operand, captured with an accepted start
//   shamt   shift count, captured with an accepted start
//   result  shifted value (registered, held after done)
//   done    one-cycle pulse, result valid
//   busy    sequencer not idle
//   stall   freeze PC/writeback
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for start; operand/count/op captured on accept
// S_SHIFT | one 1-bit step per clock until the count runs out
// S_DONE  | result valid, done pulses; always returns to S_IDLE

module shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             stall
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        op_d    = op_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = src;
                    cnt_d   = shamt;
                    op_d    = op;
                    // A zero count skips SHIFT so done follows the start cycle.
                    state_d = (shamt != '0) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                case (op_q)
                    2'b00:   acc_d = {acc_q[WIDTH-2:0], 1'b0};
                    2'b01:   acc_d = {1'b0, acc_q[WIDTH-1:1]};
                    2'b10:   acc_d = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
                    default: acc_d = {acc_q[0], acc_q[WIDTH-1:1]};
                endcase
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == SHW'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // start is ignored here; the requester keeps it held.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign result = acc_q;
    assign done   = (state_q == S_DONE);
    assign busy   = (state_q != S_IDLE);
    // Low in DONE so the instruction retires in that cycle.
    assign stall  = (start && (state_q == S_IDLE)) || (state_q == S_SHIFT);

endmodule
